row_scan_ctrl: RTL
==================

Name: row_scan_ctrl

Overview:
Sequencer for the tetris row burst-read path. On a start pulse it walks every playfield row from the bottom (row NUM_ROWS-1) to the top (row 0). For each row it issues a row_ld request, waits for row_ready, and classifies the captured read_reg words as full or not full. It produces a full-row bitmap, a count and the lowest full row, which the line-clear logic consumes, and it recovers from lost read handshakes with a timeout and retry.

Parameters:
NUM_ROWS, 20, playfield rows scanned (1..255)
NUM_COLS, 10, words per row checked from read_reg (1..10)
BKGD_CLR, 16'h000F, background colour word; any other value is an occupied cell
TIMEOUT, 1023, max clk cycles waiting for row_ready before retry
MAX_RETRY, 3, retries per row before abort

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle scan request; ignored while busy=1
abort  in  1  level; forces return to IDLE, takes priority over all other inputs
row_ready  in  1  one-cycle pulse from the row reader: read_reg is valid in this cycle
read_reg  in  16 x 10  captured row words; index 0 = leftmost column
row_ld  out  1  one-cycle pulse requesting a burst read of row
row  out  8  row index under request; stable from row_ld until row_ready or retry
busy  out  1  high from the cycle after start until the cycle done pulses
done  out  1  one-cycle pulse when a scan ends, whether completed or errored
err  out  1  set when a row exhausts its retries; cleared on next accepted start
full_mask  out  NUM_ROWS  bit r set = row r is full; valid when done pulses
full_count  out  5  number of full rows (saturates at 31)
lowest_full  out  8  largest full row index; 8'hFF if none

Behaviour:
- Reset (asynchronous): state=IDLE. row_ld=0, row=0, busy=0, done=0, err=0, full_mask=0, full_count=0, lowest_full=8'hFF. Retry counter and timer are 0.
- States: IDLE, ISSUE, WAIT, EVAL, NEXT, FIN.
- IDLE:
  - start=1 -> clear full_mask, full_count, err and retry; set lowest_full=8'hFF; row=NUM_ROWS-1; busy=1; go to ISSUE.
- ISSUE: row_ld=1 for exactly this one cycle. Timer cleared. Go to WAIT.
- WAIT:
  - row_ready=1 -> register the comparison result (all NUM_COLS words != BKGD_CLR) and go to EVAL. read_reg is sampled only in this cycle.
  - Otherwise the timer increments. When it reaches TIMEOUT: if retry<MAX_RETRY, then retry++ and go to ISSUE with the same row. Else set err=1 and go to FIN.
  - A row_ready that arrives in the same cycle as the timeout wins; no retry occurs.
- EVAL: if the row is full, set full_mask[row]. Increment full_count, saturating. If lowest_full==8'hFF, load it with row; this gives the first full row encountered, which is the bottom-most. Go to NEXT.
- NEXT:
  - row==0 -> go to FIN.
  - Else row--, retry=0, go to ISSUE.
  - row never wraps below 0.
- FIN: done=1 for one cycle; busy=0 in the same cycle; go to IDLE. full_mask, full_count, lowest_full and err hold until the next accepted start.
- A row_ready outside WAIT is ignored. This includes a late pulse from a timed-out request.
- abort in any non-IDLE state -> IDLE next cycle.
  - busy=0 and row_ld=0 that cycle; no done pulse.
  - Results are left partial; err is unchanged.
- start together with abort: abort wins and the scan does not start.
- Latency with an immediate row_ready in the cycle after row_ld: 4 cycles per row (ISSUE, WAIT, EVAL, NEXT). The full scan is 4*NUM_ROWS+1 cycles from start to done.
- Width rule: row_index compare is full 8-bit; the column compare loop covers indices 0..NUM_COLS-1 only.

Test Plan:
1. Reset then start, all rows BKGD_CLR, row_ready 1 cycle after each row_ld -> row_ld sequence is rows 19..0 (20 pulses); done at cycle 81; full_mask=0, full_count=0, lowest_full=8'hFF, err=0.
2. Rows 19 and 17 all 16'h0F00, rest BKGD_CLR -> full_mask=20'h A0000, full_count=2, lowest_full=19.
3. Row 5 has nine 16'h0F00 words and column 9 = 16'h000F -> row 5 is not full; full_mask[5]=0.
4. TIMEOUT=15 in the bench; drop row_ready for row 12 twice, then respond -> row_ld for row 12 three times, spaced 17 cycles apart; scan completes with err=0.
5. Never respond for row 12 -> 4 row_ld pulses for row 12; err=1; done pulses; rows 11..0 are never requested.
6. Assert abort in WAIT of row 10, with start also high during busy -> IDLE next cycle, no done pulse; the start issued while busy is ignored; reset asserted mid-scan returns all outputs to their reset values immediately.

Source files
------------

// File: rtl/row_scan_ctrl.sv
// row_scan_ctrl: row scan sequencer for the playfield line-clear path.
// On start it requests every row from the bottom (NUM_ROWS-1) up to row 0.
// For each row it pulses row_ld, waits for row_ready, then checks whether
// every read_reg word differs from the background colour. A missing
// row_ready is retried after TIMEOUT cycles, up to MAX_RETRY times per row,
// after which the scan ends with err set.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   start                one-cycle scan request (ignored while busy)
//   abort                level, returns to IDLE from any active state
//   row_ready            read_reg holds the requested row this cycle
//   read_reg[9:0]        row words, index 0 = leftmost column
//   row_ld, row          read request pulse and requested row index
//   busy, done, err      scan status
//   full_mask            bit r set = row r full
//   full_count           number of full rows (saturating)
//   lowest_full          largest full row index, 8'hFF if none

// Per-column occupancy check: one instance per compared column.
module row_scan_word_chk #(
  parameter logic [15:0] BKGD_CLR = 16'h000F
) (
  input  logic [15:0] word,
  output logic        occ
);
  assign occ = (word != BKGD_CLR);
endmodule

module row_scan_ctrl #(
  parameter int          NUM_ROWS  = 20,
  parameter int          NUM_COLS  = 10,
  parameter logic [15:0] BKGD_CLR  = 16'h000F,
  parameter int          TIMEOUT   = 1023,
  parameter int          MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 row_ready,
  input  logic [9:0][15:0]     read_reg,
  output logic                 row_ld,
  output logic [7:0]           row,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [NUM_ROWS-1:0]  full_mask,
  output logic [4:0]           full_count,
  output logic [7:0]           lowest_full
);

  localparam int TW = (TIMEOUT < 1)   ? 1 : $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, NEXT, FIN} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [RW-1:0]   retry;
  logic            full_q;
  logic [NUM_COLS-1:0] occ;
  logic            row_full;

  // Only columns 0..NUM_COLS-1 take part in the full-row decision.
  generate
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      row_scan_word_chk #(.BKGD_CLR(BKGD_CLR)) u_chk (
        .word (read_reg[c]),
        .occ  (occ[c])
      );
    end
  endgenerate

  assign row_full = &occ;

  // row_ld is registered: it is raised on every transition into ISSUE and
  // dropped on the way out, so it is high for exactly the ISSUE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      retry       <= '0;
      full_q      <= 1'b0;
      row_ld      <= 1'b0;
      row         <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      full_mask   <= '0;
      full_count  <= 5'd0;
      lowest_full <= 8'hFF;
    end else if (abort && state != IDLE) begin
      // Results are deliberately left partial; no done pulse.
      state  <= IDLE;
      row_ld <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            full_mask   <= '0;
            full_count  <= 5'd0;
            err         <= 1'b0;
            retry       <= '0;
            lowest_full <= 8'hFF;
            row         <= 8'(NUM_ROWS - 1);
            busy        <= 1'b1;
            row_ld      <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          row_ld <= 1'b0;
          timer  <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          // A row_ready coinciding with the timeout takes precedence.
          if (row_ready) begin
            full_q <= row_full;
            state  <= EVAL;
          end else if (timer == TW'(TIMEOUT)) begin
            if (retry < RW'(MAX_RETRY)) begin
              retry  <= retry + 1'b1;
              row_ld <= 1'b1;
              state  <= ISSUE;
            end else begin
              err   <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FIN;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        EVAL: begin
          if (full_q) begin
            for (int r = 0; r < NUM_ROWS; r++)
              if (row == 8'(r)) full_mask[r] <= 1'b1;
            if (full_count != 5'd31) full_count <= full_count + 5'd1;
            // Scan runs bottom-up, so the first hit is the bottom-most row.
            if (lowest_full == 8'hFF) lowest_full <= row;
          end
          state <= NEXT;
        end
        NEXT: begin
          if (row == 8'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end else begin
            row    <= row - 8'd1;
            retry  <= '0;
            row_ld <= 1'b1;
            state  <= ISSUE;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
